// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate backed by a word-organised memory with configurable wait states,
// two-cycle ERROR response, byte-lane writes and read-after-write forwarding.
module ahb_sub_mem #(
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          Depth      = 256,
    parameter int unsigned          WaitStates = 0,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 ready,
    input  logic [1:0]           trans,
    input  logic                 write,
    input  logic [2:0]           size,
    input  logic [AddrWidth-1:0] addr,
    input  logic [DataWidth-1:0] wData,
    output logic [DataWidth-1:0] rData,
    output logic                 readyOut,
    output logic                 resp
);
    localparam int unsigned Bytes     = DataWidth / 8;
    localparam int unsigned LaneShift = $clog2(Bytes);
    localparam int unsigned IdxW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [3:0]  LastWait  = 4'((WaitStates > 0) ? WaitStates - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
    state_t state, state_next;

    logic [DataWidth-1:0] mem [Depth];
    logic [IdxW-1:0]      idx_q;
    logic [Bytes-1:0]     be_q;
    logic                 wr_q;
    logic [3:0]           cnt;

    logic                 accept, capture, legal, borrow, commit, rd_load;
    logic [AddrWidth-1:0] offset, word_idx, align_mask;
    logic [31:0]          lane;
    logic [IdxW-1:0]      idx_new;
    logic [Bytes-1:0]     be_new;
    logic [DataWidth-1:0] wmask, merged, rd_word;

    always_comb begin
        accept     = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
        capture    = accept && sel && ready && trans[1];
        {borrow, offset} = {1'b0, addr} - {1'b0, BaseAddr};
        word_idx   = offset >> LaneShift;
        align_mask = (AddrWidth'(1) << size) - AddrWidth'(1);
        legal      = !borrow
                  && (64'(word_idx) < 64'(Depth))
                  && ((32'd8 << size) <= DataWidth)
                  && ((addr & align_mask) == '0);
        idx_new    = word_idx[IdxW-1:0];
        lane       = 32'(addr & AddrWidth'(Bytes - 1));

        be_new = '0;
        wmask  = '0;
        for (int unsigned b = 0; b < Bytes; b++) begin
            be_new[b]       = (b >= lane) && (b < lane + (32'd1 << size));
            wmask[8*b +: 8] = {8{be_q[b]}};
        end
        merged = (mem[idx_q] & ~wmask) | (wData & wmask);
        commit = (state == S_DATA) && wr_q && !reset;

        // A zero-wait read captured while a write to the same word completes sees the merged word.
        rd_load = 1'b0;
        rd_word = mem[idx_q];
        if (capture && legal && (WaitStates == 0) && !write) begin
            rd_load = 1'b1;
            rd_word = (commit && (idx_q == idx_new)) ? merged : mem[idx_new];
        end else if ((state == S_WAIT) && (cnt == LastWait) && !wr_q) begin
            rd_load = 1'b1;
        end

        state_next = state;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!capture)             state_next = S_IDLE;
                else if (!legal)          state_next = S_ERR1;
                else if (WaitStates == 0) state_next = S_DATA;
                else                      state_next = S_WAIT;
            end
            S_WAIT:  if (cnt == LastWait) state_next = S_DATA;
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            readyOut <= 1'b1;
            resp     <= 1'b0;
            rData    <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            readyOut <= (state_next == S_IDLE) || (state_next == S_DATA) || (state_next == S_ERR2);
            resp     <= (state_next == S_ERR1) || (state_next == S_ERR2);
            cnt      <= ((state == S_WAIT) && (state_next == S_WAIT)) ? cnt + 4'd1 : '0;
            if (rd_load) rData <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            idx_q <= idx_new;
            be_q  <= be_new;
            wr_q  <= write;
        end
        if (commit) mem[idx_q] <= merged;
    end
endmodule
